// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target exposing a byte-wide register file behind an
// auto-incrementing pointer, with a host-side write port and a write strobe
// reporting every register updated by the bus master.
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3,
   localparam int        PTR_W      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic             host_we,
   input  logic [PTR_W-1:0] host_addr,
   input  logic [7:0]       host_wdata,
   output logic             wr_stb,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
   } state_t;

   // ---------------------------------------------------------------
   // Bus conditioning
   // ---------------------------------------------------------------
   logic [1:0]            scl_sync_q, sda_sync_q;
   logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
   logic                  fscl_q, fsda_q, fscl_prev_q, fsda_prev_q;

   // Synchronize both lines, keep a short sample history, and only accept a
   // new level once every sample in the history agrees.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_hist_q  <= '1;
         sda_hist_q  <= '1;
         fscl_q      <= 1'b1;
         fsda_q      <= 1'b1;
         fscl_prev_q <= 1'b1;
         fsda_prev_q <= 1'b1;
      end else begin
         scl_sync_q  <= {scl_sync_q[0], scl};
         sda_sync_q  <= {sda_sync_q[0], sda_i};
         scl_hist_q  <= (scl_hist_q << 1) | FILTER_LEN'(scl_sync_q[1]);
         sda_hist_q  <= (sda_hist_q << 1) | FILTER_LEN'(sda_sync_q[1]);
         if (&scl_hist_q)       fscl_q <= 1'b1;
         else if (~|scl_hist_q) fscl_q <= 1'b0;
         if (&sda_hist_q)       fsda_q <= 1'b1;
         else if (~|sda_hist_q) fsda_q <= 1'b0;
         fscl_prev_q <= fscl_q;
         fsda_prev_q <= fsda_q;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  =  fscl_q & ~fscl_prev_q;
   assign scl_fall  = ~fscl_q &  fscl_prev_q;
   assign start_det =  fscl_q &  fscl_prev_q &  fsda_prev_q & ~fsda_q;
   assign stop_det  =  fscl_q &  fscl_prev_q & ~fsda_prev_q &  fsda_q;

   // ---------------------------------------------------------------
   // Protocol FSM
   // ---------------------------------------------------------------
   state_t           state_q, state_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             rw_q, rw_d;
   logic             i2c_we;
   logic [7:0]       new_byte;
   logic [7:0]       regs_q [NUM_REGS];

   // State register plus the shift/pointer datapath it controls
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         ptr_q    <= '0;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         rw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         rw_q     <= rw_d;
      end
   end

   // Next-state decode: bus conditions first, then per-state bit handling.
   // Bits are taken on fscl rise; SDA is only changed on fscl fall.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      rw_d     = rw_q;
      i2c_we   = 1'b0;
      new_byte = {shift_q[6:0], fsda_q};

      if (stop_det) begin
         state_d  = IDLE;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d  = ADDR;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift_d  = new_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     bitcnt_d = '0;
                     if (state_q == ADDR) begin
                        if (new_byte[7:1] == DEV_ADDR) begin
                           state_d = ADDR_ACK;
                           busy_d  = 1'b1;
                           rw_d    = new_byte[0];
                        end else begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = new_byte[PTR_W-1:0];
                        state_d = PTR_ACK;
                     end else begin
                        i2c_we  = 1'b1;
                        state_d = WDATA_ACK;
                     end
                  end
               end
            end
            // First fall drives the ACK low, the next one ends the ACK slot.
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = '0;
                     if (state_q == WDATA_ACK) begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = WDATA;
                     end else if (state_q == PTR_ACK) begin
                        state_d = WDATA;
                     end else if (rw_q) begin
                        state_d  = RDATA;
                        shift_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                     end else begin
                        state_d = PTR;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     state_d  = RDATA_ACK;
                     sda_oe_d = 1'b0;
                     bitcnt_d = '0;
                  end else begin
                     shift_d  = {shift_q[6:0], shift_q[7]};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            // bitcnt marks that the master ACKed and another byte is due
            RDATA_ACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_q + 1'b1;
                  if (fsda_q) state_d  = WAIT;
                  else        bitcnt_d = 4'd1;
               end else if (scl_fall && bitcnt_q == 4'd1) begin
                  state_d  = RDATA;
                  bitcnt_d = '0;
                  shift_d  = regs_q[ptr_q];
                  sda_oe_d = ~regs_q[ptr_q][7];
               end
            end
            default: ;
         endcase
      end
   end

   // Register file: a bus write beats a host write to the same index
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i2c_we && ptr_q == PTR_W'(i))
               regs_q[i] <= new_byte;
            else if (host_we && host_addr == PTR_W'(i))
               regs_q[i] <= host_wdata;
         end
      end
   end

   logic             wr_stb_q;
   logic [PTR_W-1:0] wr_addr_q;
   logic [7:0]       wr_data_q;

   // One-clk report of each bus-originated register write
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_stb_q <= i2c_we;
         if (i2c_we) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= new_byte;
         end
      end
   end

   assign sda_oe  = sda_oe_q;
   assign busy    = busy_q;
   assign wr_stb  = wr_stb_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule
